fma_unit: RTL and testbench

Per-thread Q1.15 fused multiply-accumulate unit. It sits in each thread's datapath beside the ALU, takes the `rs`/`rt` operands from that thread's register file, and drives `fma_out`, which the register file writes back on the FMA mux path during UPDATE. The unit keeps one internal 16-bit accumulator per thread and computes the result over a 3-cycle multi-cycle FSM. A ready flag tells the core scheduler when it may leave EXECUTE.

---
 rtl/fma_unit.sv | 148 ++++++++++++++
 tb/tb_fma_unit.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/fma_unit.sv
// Per-thread Q1.15 fused multiply-accumulate unit with one 16-bit accumulator.
// A 3-cycle FSM (MULTIPLY, ACCUMULATE, DONE) raises fma_ready for the core scheduler.
module fma_unit #(
  parameter int DATA_BITS = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic                 decoded_fma_enable,
  input  logic                 decoded_fma_clear,
  input  logic [DATA_BITS-1:0] rs,
  input  logic [DATA_BITS-1:0] rt,
  output logic [DATA_BITS-1:0] fma_out,
  output logic                 fma_ready,
  output logic                 fma_sat,
  output logic [1:0]           dbg_state
);

  localparam logic [2:0] CORE_EXECUTE = 3'b101;
  localparam logic [2:0] CORE_UPDATE  = 3'b110;
  localparam int         PW           = 2 * DATA_BITS;

  localparam logic signed [PW-1:0]        RND_HALF = PW'(1) << (DATA_BITS - 2);
  localparam logic signed [DATA_BITS:0]   POS_MAX  = {2'b00, {(DATA_BITS-1){1'b1}}};
  localparam logic [DATA_BITS-1:0]        Q_MAX    = {1'b0, {(DATA_BITS-1){1'b1}}};
  localparam logic [DATA_BITS-1:0]        Q_MIN    = {1'b1, {(DATA_BITS-1){1'b0}}};

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    MULTIPLY   = 2'd1,
    ACCUMULATE = 2'd2,
    DONE       = 2'd3
  } state_t;

  state_t state, next_state;

  logic [DATA_BITS-1:0] rs_q, rt_q, prod_q, acc;
  logic                 clear_q, sat_q, ready_q;

  logic [DATA_BITS-1:0] rs_n, rt_n, prod_n, acc_n;
  logic                 clear_n, sat_n;

  logic                 start;
  logic signed [PW-1:0] p_full;
  logic signed [PW-1:0] p_rnd;
  logic signed [DATA_BITS:0] pr;
  logic                 prod_clamp;
  logic [DATA_BITS-1:0] prod_val;
  logic [DATA_BITS-1:0] addend;
  logic [DATA_BITS:0]   sum;
  logic                 sum_pos_ovf, sum_neg_ovf;
  logic [DATA_BITS-1:0] sum_val;

  assign start = enable && (core_state == CORE_EXECUTE) && decoded_fma_enable;

  // Round-half-up product: add half an LSB of Q1.15 then arithmetic shift by 15.
  assign p_full     = $signed(rs_q) * $signed(rt_q);
  assign p_rnd      = p_full + RND_HALF;
  assign pr         = p_rnd[PW-1:DATA_BITS-1];
  assign prod_clamp = (pr > POS_MAX);
  assign prod_val   = prod_clamp ? Q_MAX : pr[DATA_BITS-1:0];

  // 17-bit sum; the top two bits disagreeing means the Q1.15 range was left.
  assign addend      = clear_q ? '0 : acc;
  assign sum         = {prod_q[DATA_BITS-1], prod_q} + {addend[DATA_BITS-1], addend};
  assign sum_pos_ovf = (sum[DATA_BITS:DATA_BITS-1] == 2'b01);
  assign sum_neg_ovf = (sum[DATA_BITS:DATA_BITS-1] == 2'b10);
  assign sum_val     = sum_pos_ovf ? Q_MAX :
                       sum_neg_ovf ? Q_MIN : sum[DATA_BITS-1:0];

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready_q <= 1'b0;
    end else begin
      state   <= next_state;
      ready_q <= (next_state == DONE);
    end
  end

  always_comb begin
    next_state = state;
    if (enable) begin
      case (state)
        IDLE:       if (start) next_state = MULTIPLY;
        MULTIPLY:   next_state = ACCUMULATE;
        ACCUMULATE: next_state = DONE;
        DONE:       if (core_state == CORE_UPDATE) next_state = IDLE;
        default:    next_state = IDLE;
      endcase
    end
  end

  // Datapath register updates; everything holds while enable is low.
  always_comb begin
    rs_n    = rs_q;
    rt_n    = rt_q;
    clear_n = clear_q;
    prod_n  = prod_q;
    acc_n   = acc;
    sat_n   = sat_q;
    if (enable) begin
      case (state)
        IDLE: begin
          if (start) begin
            rs_n    = rs;
            rt_n    = rt;
            clear_n = decoded_fma_clear;
          end
        end
        MULTIPLY: begin
          prod_n = prod_val;
          sat_n  = (clear_q ? 1'b0 : sat_q) | prod_clamp;
        end
        ACCUMULATE: begin
          acc_n = sum_val;
          sat_n = sat_q | sum_pos_ovf | sum_neg_ovf;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rs_q    <= '0;
      rt_q    <= '0;
      clear_q <= 1'b0;
      prod_q  <= '0;
      acc     <= '0;
      sat_q   <= 1'b0;
    end else begin
      rs_q    <= rs_n;
      rt_q    <= rt_n;
      clear_q <= clear_n;
      prod_q  <= prod_n;
      acc     <= acc_n;
      sat_q   <= sat_n;
    end
  end

  assign fma_out   = acc;
  assign fma_ready = ready_q;
  assign fma_sat   = sat_q;
  assign dbg_state = state;

endmodule

// File: tb/tb_fma_unit.sv
// Directed bench for fma_unit: hand-computed Q1.15 vectors checked with
// immediate assertions, expected results queued in a small scoreboard.
module tb_fma_unit;

  localparam logic [2:0] EXECUTE = 3'b101;
  localparam logic [2:0] UPDATE  = 3'b110;
  localparam logic [2:0] OTHER   = 3'b000;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [2:0]  core_state;
  logic        decoded_fma_enable;
  logic        decoded_fma_clear;
  logic [15:0] rs, rt;
  logic [15:0] fma_out;
  logic        fma_ready;
  logic        fma_sat;
  logic [1:0]  dbg_state;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q[$];

  fma_unit #(.DATA_BITS(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .enable             (enable),
    .core_state         (core_state),
    .decoded_fma_enable (decoded_fma_enable),
    .decoded_fma_clear  (decoded_fma_clear),
    .rs                 (rs),
    .rt                 (rt),
    .fma_out            (fma_out),
    .fma_ready          (fma_ready),
    .fma_sat            (fma_sat),
    .dbg_state          (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic start_op(input logic [15:0] a, input logic [15:0] b, input logic clr);
    enable             = 1'b1;
    core_state         = EXECUTE;
    decoded_fma_enable = 1'b1;
    decoded_fma_clear  = clr;
    rs                 = a;
    rt                 = b;
    step();
  endtask

  task automatic finish_op(input string tag);
    core_state = UPDATE;
    step();
    chk({tag, "_ready_fall"}, 32'(fma_ready), 32'd0);
    chk({tag, "_idle"}, 32'(dbg_state), 32'd0);
    core_state         = OTHER;
    decoded_fma_enable = 1'b0;
  endtask

  task automatic run_fma(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic clr, input logic [15:0] exp, input logic exp_sat);
    exp_q.push_back(exp);
    start_op(a, b, clr);
    step();
    chk({tag, "_ready_early"}, 32'(fma_ready), 32'd0);
    step();
    chk({tag, "_ready"}, 32'(fma_ready), 32'd1);
    chk({tag, "_out"}, 32'(fma_out), 32'(exp_q.pop_front()));
    chk({tag, "_sat"}, 32'(fma_sat), 32'(exp_sat));
    finish_op(tag);
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; core_state = OTHER;
    decoded_fma_enable = 1'b0; decoded_fma_clear = 1'b0; rs = '0; rt = '0;
    step();
    step();
    chk("rst_out", 32'(fma_out), 32'h0000);
    chk("rst_ready", 32'(fma_ready), 32'd0);
    chk("rst_sat", 32'(fma_sat), 32'd0);
    chk("rst_state", 32'(dbg_state), 32'd0);
    reset = 1'b0;
    step();

    // basic and accumulate
    run_fma("clr_basic", 16'h4000, 16'h4000, 1'b1, 16'h2000, 1'b0);
    run_fma("acc_basic", 16'h4000, 16'h4000, 1'b0, 16'h4000, 1'b0);

    // negative and sign
    run_fma("clr_neg", 16'h8000, 16'h4000, 1'b1, 16'hC000, 1'b0);
    run_fma("acc_neg", 16'h4000, 16'hC000, 1'b0, 16'hA000, 1'b0);

    // rounding
    run_fma("rnd_half", 16'h0001, 16'h4000, 1'b1, 16'h0001, 1'b0);
    run_fma("rnd_negh", 16'hFFFF, 16'h4000, 1'b1, 16'h0000, 1'b0);
    run_fma("rnd_tiny", 16'h0001, 16'h0001, 1'b1, 16'h0000, 1'b0);

    // saturation
    run_fma("sat_prod", 16'h8000, 16'h8000, 1'b1, 16'h7FFF, 1'b1);
    run_fma("sat_sum",  16'h4000, 16'h4000, 1'b0, 16'h7FFF, 1'b1);
    run_fma("sat_clr",  16'h2000, 16'h2000, 1'b1, 16'h0800, 1'b0);
    run_fma("neg_min",  16'h8000, 16'h7FFF, 1'b1, 16'h8001, 1'b0);
    run_fma("sat_neg",  16'h8000, 16'h4000, 1'b0, 16'h8000, 1'b1);

    // non-FMA instruction in EXECUTE: unit must not start
    enable = 1'b1; core_state = EXECUTE; decoded_fma_enable = 1'b0;
    repeat (3) step();
    chk("nofma_ready", 32'(fma_ready), 32'd0);
    chk("nofma_state", 32'(dbg_state), 32'd0);
    chk("nofma_out", 32'(fma_out), 32'h8000);
    core_state = OTHER;

    // hold in DONE while the core stays in EXECUTE
    exp_q.push_back(16'h1000);
    start_op(16'h4000, 16'h2000, 1'b1);
    step();
    step();
    for (int i = 0; i < 10; i++) begin
      chk("hold_ready", 32'(fma_ready), 32'd1);
      chk("hold_out", 32'(fma_out), 32'(exp_q[0]));
      step();
    end
    void'(exp_q.pop_front());
    finish_op("hold");

    // freeze for 4 cycles in MULTIPLY while rs wanders
    exp_q.push_back(16'h1800);
    start_op(16'h2000, 16'h2000, 1'b0);
    enable = 1'b0;
    for (int i = 0; i < 4; i++) begin
      rs = 16'($urandom_range(0, 16'hFFFF));
      rt = 16'($urandom_range(0, 16'hFFFF));
      step();
      chk("frz_state", 32'(dbg_state), 32'd1);
      chk("frz_ready", 32'(fma_ready), 32'd0);
    end
    enable = 1'b1;
    step();
    chk("frz_ready_early", 32'(fma_ready), 32'd0);
    step();
    chk("frz_ready", 32'(fma_ready), 32'd1);
    chk("frz_out", 32'(fma_out), 32'(exp_q.pop_front()));
    finish_op("frz");

    // operand toggling after the start edge is ignored
    exp_q.push_back(16'h2000);
    start_op(16'h4000, 16'h4000, 1'b1);
    rs = 16'h7FFF; rt = 16'h0001;
    step();
    rs = 16'h0000;
    step();
    chk("tog_ready", 32'(fma_ready), 32'd1);
    chk("tog_out", 32'(fma_out), 32'(exp_q.pop_front()));
    finish_op("tog");

    // reset in ACCUMULATE discards the in-flight result
    start_op(16'h4000, 16'h4000, 1'b0);
    step();
    chk("rmid_state", 32'(dbg_state), 32'd2);
    reset = 1'b1; core_state = OTHER; decoded_fma_enable = 1'b0;
    step();
    reset = 1'b0;
    chk("rmid_out", 32'(fma_out), 32'h0000);
    chk("rmid_ready", 32'(fma_ready), 32'd0);
    chk("rmid_sat", 32'(fma_sat), 32'd0);
    chk("rmid_state_idle", 32'(dbg_state), 32'd0);
    step();
    run_fma("post_rst", 16'h4000, 16'h4000, 1'b0, 16'h2000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
